// File: rtl/grid_pkg.sv
// Shared constants, command/state encodings and point/index helpers for the grid editor.
package grid_pkg;
  localparam int GRID_W  = 64;
  localparam int GRID_H  = 60;
  localparam int N_WORDS = 960;

  localparam logic [7:0] CELL_EMPTY = 8'd0;
  localparam logic [7:0] CELL_START = 8'd1;
  localparam logic [7:0] CELL_END   = 8'd2;
  localparam logic [7:0] CELL_PATH  = 8'd3;
  localparam logic [7:0] CELL_WALL  = 8'd4;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_WALL       = 3'd1,
    OP_ERASE      = 3'd2,
    OP_SET_START  = 3'd3,
    OP_SET_END    = 3'd4,
    OP_CLEAR_PATH = 3'd5,
    OP_CLEAR_ALL  = 3'd6,
    OP_NOP7       = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE_OLD,
    S_WRITE_CELL,
    S_SWEEP_RD,
    S_SWEEP_CHK,
    S_SWEEP_WR,
    S_FILL,
    S_ERR
  } state_e;

  // Point layout {X[5:0], Y[5:0], valid}
  function automatic logic [12:0] pack_point(input logic [5:0] x, input logic [5:0] y,
                                             input logic vld);
    return {x, y, vld};
  endfunction

  // Index = X + 64*Y; word address is index[11:2], byte lane is index[1:0]
  function automatic logic [11:0] cell_index(input logic [5:0] x, input logic [5:0] y);
    return {y, x};
  endfunction

  function automatic logic is_border(input logic [11:0] idx);
    return (idx[5:0] == 6'd0) || (idx[5:0] == 6'(GRID_W - 1)) ||
           (idx[11:6] == 6'd0) || (idx[11:6] == 6'(GRID_H - 1));
  endfunction

  function automatic logic [7:0] op_code(input op_e op);
    logic [7:0] c;
    c = CELL_EMPTY;
    case (op)
      OP_WALL:      c = CELL_WALL;
      OP_SET_START: c = CELL_START;
      OP_SET_END:   c = CELL_END;
      default:      c = CELL_EMPTY;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/grid_byte_lane.sv
// Steers one cell code into its byte lane of a 4-cell PixelOCM word (one-hot BYTE_EN + aligned data).
// Purely combinational; also used by the path core's trace write.
module grid_byte_lane (
  input  logic [1:0]  lane_i,
  input  logic [7:0]  code_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o
);
  always_comb begin
    byte_en_o = 4'b0001 << lane_i;
    wdata_o   = {24'b0, code_i} << {lane_i, 3'b000};
  end
endmodule

// File: rtl/grid_editor.sv
// Turns DRAW-phase edit commands into PixelOCM byte writes, keeps Start/End points, sweeps path cells.
// Define GRID_BORDER_EN to fill the grid border with walls on CLEAR_ALL and lock border cells.
module grid_editor
  import grid_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        lock,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [5:0]  cmd_x,
  input  logic [5:0]  cmd_y,
  output logic        cmd_err,
  output logic        busy,
  output logic [12:0] StartPoint,
  output logic [12:0] EndPoint,
  output logic        AVL_READ,
  output logic        AVL_WRITE,
  output logic        AVL_CS,
  output logic [3:0]  AVL_BYTE_EN,
  output logic [9:0]  AVL_ADDRESS,
  output logic [31:0] AVL_WRITEDATA,
  input  logic [31:0] AVL_READDATA,
  input  logic        AVL_WAIT_REQUEST
);
  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [5:0]  tx_q, tx_d, ty_q, ty_d;
  logic [12:0] start_q, start_d, end_q, end_d;
  logic [9:0]  w_q, w_d;
  logic [3:0]  mask_q, mask_d;

  op_e         cmd_op_e;
  logic        cmd_acc, bad_cell, hits_start, hits_end, last_word;
  logic [3:0]  sweep_mask;
  logic [11:0] old_xy, old_idx, tgt_idx;
  logic [1:0]  lane_sel;
  logic [7:0]  lane_code;
  logic [3:0]  lane_be;
  logic [31:0] lane_data, fill_word;

  assign cmd_op_e   = op_e'(cmd_op);
  assign cmd_ready  = (state_q == S_IDLE) && !lock;
  assign cmd_acc    = cmd_valid && cmd_ready;
  assign busy       = (state_q != S_IDLE);
  assign cmd_err    = (state_q == S_ERR);
  assign StartPoint = start_q;
  assign EndPoint   = end_q;
  assign last_word  = (w_q == 10'(N_WORDS - 1));
  assign hits_start = start_q[0] && (start_q[12:1] == {cmd_x, cmd_y});
  assign hits_end   = end_q[0] && (end_q[12:1] == {cmd_x, cmd_y});
  assign old_xy     = (op_q == OP_SET_END) ? end_q[12:1] : start_q[12:1];
  assign old_idx    = cell_index(old_xy[11:6], old_xy[5:0]);
  assign tgt_idx    = cell_index(tx_q, ty_q);
  assign lane_sel   = (state_q == S_ERASE_OLD) ? old_idx[1:0] : tgt_idx[1:0];
  assign lane_code  = (state_q == S_ERASE_OLD) ? CELL_EMPTY : op_code(op_q);

  grid_byte_lane u_lane (
    .lane_i    (lane_sel),
    .code_i    (lane_code),
    .byte_en_o (lane_be),
    .wdata_o   (lane_data)
  );

  always_comb begin
    bad_cell = (cmd_y > 6'(GRID_H - 1));
`ifdef GRID_BORDER_EN
    bad_cell = bad_cell || is_border(cell_index(cmd_x, cmd_y));
`endif
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sweep_mask[k] = (AVL_READDATA[8*k +: 8] == CELL_PATH);
    end
  end

  always_comb begin
    fill_word = '0;
`ifdef GRID_BORDER_EN
    for (int k = 0; k < 4; k++) begin
      if (is_border({w_q, 2'(k)})) fill_word[8*k +: 8] = CELL_WALL;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    start_d = start_q;
    end_d   = end_q;
    w_d     = w_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          op_d = cmd_op_e;
          tx_d = cmd_x;
          ty_d = cmd_y;
          w_d  = '0;
          case (cmd_op_e)
            OP_WALL, OP_ERASE: state_d = bad_cell ? S_ERR : S_WRITE_CELL;
            OP_SET_START: begin
              if (bad_cell || hits_end)            state_d = S_ERR;
              else if (start_q[0] && !hits_start)  state_d = S_ERASE_OLD;
              else                                 state_d = S_WRITE_CELL;
            end
            OP_SET_END: begin
              if (bad_cell || hits_start)          state_d = S_ERR;
              else if (end_q[0] && !hits_end)      state_d = S_ERASE_OLD;
              else                                 state_d = S_WRITE_CELL;
            end
            OP_CLEAR_PATH: state_d = S_SWEEP_RD;
            OP_CLEAR_ALL: begin
              state_d    = S_FILL;
              start_d[0] = 1'b0;
              end_d[0]   = 1'b0;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_ERASE_OLD: if (!AVL_WAIT_REQUEST) state_d = S_WRITE_CELL;
      S_WRITE_CELL: begin
        if (!AVL_WAIT_REQUEST) begin
          state_d = S_IDLE;
          case (op_q)
            OP_SET_START: start_d = pack_point(tx_q, ty_q, 1'b1);
            OP_SET_END:   end_d   = pack_point(tx_q, ty_q, 1'b1);
            default: begin
              // Overwriting an endpoint cell leaves that endpoint without a marker
              if (start_q[12:1] == {tx_q, ty_q}) start_d[0] = 1'b0;
              if (end_q[12:1] == {tx_q, ty_q})   end_d[0]   = 1'b0;
            end
          endcase
        end
      end
      S_SWEEP_RD: if (!AVL_WAIT_REQUEST) state_d = S_SWEEP_CHK;
      S_SWEEP_CHK: begin
        mask_d = sweep_mask;
        if (sweep_mask != 4'b0000) state_d = S_SWEEP_WR;
        else if (last_word)        state_d = S_IDLE;
        else begin
          w_d     = w_q + 10'd1;
          state_d = S_SWEEP_RD;
        end
      end
      S_SWEEP_WR: begin
        if (!AVL_WAIT_REQUEST) begin
          if (last_word) state_d = S_IDLE;
          else begin
            w_d     = w_q + 10'd1;
            state_d = S_SWEEP_RD;
          end
        end
      end
      S_FILL: begin
        if (!AVL_WAIT_REQUEST) begin
          if (last_word) state_d = S_IDLE;
          else           w_d = w_q + 10'd1;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs depend only on registered state, so they hold while the FSM stalls
  always_comb begin
    AVL_CS        = 1'b1;
    AVL_READ      = 1'b0;
    AVL_WRITE     = 1'b0;
    AVL_BYTE_EN   = 4'b0000;
    AVL_ADDRESS   = '0;
    AVL_WRITEDATA = '0;
    case (state_q)
      S_ERASE_OLD: begin
        AVL_WRITE     = 1'b1;
        AVL_ADDRESS   = old_idx[11:2];
        AVL_BYTE_EN   = lane_be;
        AVL_WRITEDATA = lane_data;
      end
      S_WRITE_CELL: begin
        AVL_WRITE     = 1'b1;
        AVL_ADDRESS   = tgt_idx[11:2];
        AVL_BYTE_EN   = lane_be;
        AVL_WRITEDATA = lane_data;
      end
      S_SWEEP_RD: begin
        AVL_READ    = 1'b1;
        AVL_ADDRESS = w_q;
      end
      S_SWEEP_WR: begin
        AVL_WRITE   = 1'b1;
        AVL_ADDRESS = w_q;
        AVL_BYTE_EN = mask_q;
      end
      S_FILL: begin
        AVL_WRITE     = 1'b1;
        AVL_ADDRESS   = w_q;
        AVL_BYTE_EN   = 4'hF;
        AVL_WRITEDATA = fill_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      tx_q    <= '0;
      ty_q    <= '0;
      start_q <= '0;
      end_q   <= '0;
      w_q     <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      start_q <= start_d;
      end_q   <= end_d;
      w_q     <= w_d;
      mask_q  <= mask_d;
    end
  end
endmodule

// File: tb/tb_grid_editor.sv
// Randomized bench for grid_editor: bench-side PixelOCM memory plus a cell-level model of the editor.
`timescale 1ns/1ps
module tb_grid_editor;
  localparam int NCELL = 3840;
  localparam int NW    = 960;

  logic        Clk = 1'b0;
  logic        Reset, lock, cmd_valid, cmd_ready, cmd_err, busy;
  logic [2:0]  cmd_op;
  logic [5:0]  cmd_x, cmd_y;
  logic [12:0] StartPoint, EndPoint;
  logic        AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]  AVL_BYTE_EN;
  logic [9:0]  AVL_ADDRESS;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA = 32'h0;
  logic        AVL_WAIT_REQUEST = 1'b0;

  grid_editor dut (
    .Clk(Clk), .Reset(Reset), .lock(lock), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_err(cmd_err), .busy(busy),
    .StartPoint(StartPoint), .EndPoint(EndPoint), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_CS(AVL_CS), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDRESS(AVL_ADDRESS),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .AVL_WAIT_REQUEST(AVL_WAIT_REQUEST)
  );

  always #5 Clk = ~Clk;

  typedef struct packed { logic [9:0] addr; logic [3:0] be; logic [31:0] data; } wr_t;

  logic [7:0] ram   [0:NCELL-1];
  logic [7:0] mgrid [0:NCELL-1];
  int         px [2], py [2];
  bit         pv [2];
  wr_t        wlog [$];
  int         err_cnt, force_wait, checks, fails;
  bit         rand_wait;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit border(input int x, input int y);
`ifdef GRID_BORDER_EN
    return (x == 0) || (x == 63) || (y == 0) || (y == 59);
`else
    return 1'b0;
`endif
  endfunction

  // Bench-side PixelOCM and per-cycle protocol checks
  task automatic bus_monitor();
    logic p_wait, p_rd, p_wr;
    logic [9:0] p_addr;
    logic [3:0] p_be;
    logic [31:0] p_data;
    bit rd_hold;
    int a;
    p_wait = 0; p_rd = 0; p_wr = 0; p_addr = 0; p_be = 0; p_data = 0; rd_hold = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        p_wait = 0; rd_hold = 0; AVL_WAIT_REQUEST = 0;
        continue;
      end
      chk("rd_wr_exclusive", {63'b0, AVL_READ & AVL_WRITE}, 64'd0);
      chk("cmd_ready_rule", {63'b0, cmd_ready}, {63'b0, !busy && !lock});
      chk("avl_cs", {63'b0, AVL_CS}, 64'd1);
      if (!busy) chk("idle_no_bus", {62'b0, AVL_READ, AVL_WRITE}, 64'd0);
      if (p_wait && (p_rd || p_wr))
        chk("wait_hold", {AVL_READ, AVL_WRITE, AVL_ADDRESS, AVL_BYTE_EN, AVL_WRITEDATA},
            {p_rd, p_wr, p_addr, p_be, p_data});
      if (cmd_err) err_cnt++;
      if (force_wait > 0 && AVL_WRITE) begin
        AVL_WAIT_REQUEST = 1'b1;
        force_wait--;
      end else begin
        AVL_WAIT_REQUEST = rand_wait && ($urandom_range(0, 3) == 0);
      end
      a = int'(AVL_ADDRESS);
      if (rd_hold) rd_hold = 0;
      else if (AVL_READ && !AVL_WAIT_REQUEST && a < NW) begin
        AVL_READDATA = {ram[4*a+3], ram[4*a+2], ram[4*a+1], ram[4*a]};
        rd_hold = 1;
      end else AVL_READDATA = $urandom;
      if (AVL_WRITE && !AVL_WAIT_REQUEST) begin
        if (a < NW)
          for (int k = 0; k < 4; k++)
            if (AVL_BYTE_EN[k]) ram[4*a+k] = AVL_WRITEDATA[8*k +: 8];
        wlog.push_back('{AVL_ADDRESS, AVL_BYTE_EN, AVL_WRITEDATA});
      end
      p_wait = AVL_WAIT_REQUEST; p_rd = AVL_READ; p_wr = AVL_WRITE;
      p_addr = AVL_ADDRESS; p_be = AVL_BYTE_EN; p_data = AVL_WRITEDATA;
    end
  endtask

  // Cell-level effect of one command; returns expected write count and error pulses
  task automatic model_cmd(input int op, input int x, input int y, output int ew, output int ee);
    int k, o, idx;
    bit bad, any;
    ew = 0; ee = 0;
    idx = x + 64 * y;
    bad = (y > 59) || border(x, y);
    case (op)
      1, 2: begin
        if (bad) ee = 1;
        else begin
          mgrid[idx] = (op == 1) ? 8'd4 : 8'd0;
          ew = 1;
          for (int p = 0; p < 2; p++) if (px[p] == x && py[p] == y) pv[p] = 0;
        end
      end
      3, 4: begin
        k = op - 3; o = 1 - k;
        if (bad || (pv[o] && px[o] == x && py[o] == y)) ee = 1;
        else begin
          if (pv[k] && !(px[k] == x && py[k] == y)) begin
            mgrid[px[k] + 64 * py[k]] = 8'd0;
            ew++;
          end
          mgrid[idx] = 8'(k + 1);
          ew++;
          px[k] = x; py[k] = y; pv[k] = 1;
        end
      end
      5: begin
        for (int w = 0; w < NW; w++) begin
          any = 0;
          for (int b = 0; b < 4; b++)
            if (mgrid[4*w+b] == 8'd3) begin mgrid[4*w+b] = 8'd0; any = 1; end
          if (any) ew++;
        end
      end
      6: begin
        for (int i = 0; i < NCELL; i++) mgrid[i] = border(i % 64, i / 64) ? 8'd4 : 8'd0;
        ew = NW; pv[0] = 0; pv[1] = 0;
      end
      default: ;
    endcase
  endtask

  function automatic logic [12:0] mpoint(input int p);
    return {6'(px[p]), 6'(py[p]), pv[p]};
  endfunction

  task automatic compare_state(input string tag);
    int mism, first;
    mism = 0; first = -1;
    for (int i = 0; i < NCELL; i++)
      if (ram[i] !== mgrid[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    if (mism != 0) $display("  first bad cell %0d dut=%0h model=%0h (%s)", first, ram[first], mgrid[first], tag);
    chk({tag, "_grid_cells_wrong"}, 64'(mism), 64'd0);
    chk({tag, "_StartPoint"}, {51'b0, StartPoint}, {51'b0, mpoint(0)});
    chk({tag, "_EndPoint"}, {51'b0, EndPoint}, {51'b0, mpoint(1)});
  endtask

  task automatic do_cmd(input int op, input int x, input int y, input bit lk, input string tag);
    int ew, ee, t;
    model_cmd(op, x, y, ew, ee);
    @(posedge Clk); #1;
    t = 0;
    while (!cmd_ready && t < 100) begin @(posedge Clk); #1; t++; end
    chk({tag, "_ready_timeout"}, {63'b0, cmd_ready}, 64'd1);
    wlog.delete(); err_cnt = 0;
    cmd_valid = 1; cmd_op = 3'(op); cmd_x = 6'(x); cmd_y = 6'(y);
    @(posedge Clk); #1;
    cmd_valid = 0; cmd_op = 3'($urandom_range(0, 7)); cmd_x = 6'($urandom_range(0, 63));
    if (lk) lock = 1;
    t = 0;
    while (busy && t < 20000) begin @(posedge Clk); #1; t++; end
    lock = 0;
    chk({tag, "_busy_timeout"}, {63'b0, busy}, 64'd0);
    @(negedge Clk); #1;
    chk({tag, "_write_count"}, 64'(wlog.size()), 64'(ew));
    chk({tag, "_cmd_err_pulses"}, 64'(err_cnt), 64'(ee));
    compare_state(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {63'b0, cmd_ready}, 64'd1);
    chk({tag, "_avl_cs"}, {63'b0, AVL_CS}, 64'd1);
    chk({tag, "_busy_err"}, {62'b0, busy, cmd_err}, 64'd0);
    chk({tag, "_avl_ctrl"}, {49'b0, AVL_READ, AVL_WRITE, AVL_BYTE_EN, AVL_ADDRESS}, 64'd0);
    chk({tag, "_avl_wdata"}, {32'b0, AVL_WRITEDATA}, 64'd0);
    chk({tag, "_points"}, {38'b0, StartPoint, EndPoint}, 64'd0);
  endtask

  task automatic sprinkle_path(input int n);
    int i;
    for (int j = 0; j < n; j++) begin
      i = $urandom_range(0, NCELL - 1);
      ram[i] = 8'd3; mgrid[i] = 8'd3;
    end
  endtask

  initial begin
    int ops [9] = '{0, 1, 1, 2, 3, 3, 4, 4, 7};
    int op, x, y, r, t;
    checks = 0; fails = 0; err_cnt = 0; force_wait = 0; rand_wait = 0;
    Reset = 1; lock = 0; cmd_valid = 0; cmd_op = 0; cmd_x = 0; cmd_y = 0;
    for (int i = 0; i < NCELL; i++) begin
      ram[i] = 8'($urandom_range(0, 4));
      mgrid[i] = ram[i];
    end
    for (int p = 0; p < 2; p++) begin px[p] = 0; py[p] = 0; pv[p] = 0; end
    fork bus_monitor(); join_none
    repeat (3) @(posedge Clk);
    #1 check_reset_outputs("reset");
    Reset = 0;

    // CLEAR_ALL with a 3-cycle stall at the first fill write
    force_wait = 3;
    do_cmd(6, 0, 0, 0, "fill_stall");
    chk("fill_stall_consumed", 64'(force_wait), 64'd0);

    do_cmd(1, 5, 2, 0, "wall_5_2");
    if (wlog.size() == 1) begin
      chk("wall_addr", 64'(wlog[0].addr), 64'd33);
      chk("wall_be", 64'(wlog[0].be), 64'b0010);
      chk("wall_data", 64'(wlog[0].data), 64'h0000_0400);
    end

    do_cmd(3, 1, 1, 0, "set_start_1_1");
    do_cmd(3, 2, 1, 0, "set_start_2_1");
    if (wlog.size() == 2) begin
      chk("move_erase", {30'b0, wlog[0]}, {30'b0, 10'd16, 4'b0010, 32'h0});
      chk("move_write", {30'b0, wlog[1]}, {30'b0, 10'd16, 4'b0100, 32'h0001_0000});
    end
    chk("start_literal", {51'b0, StartPoint}, {51'b0, 6'd2, 6'd1, 1'b1});

    do_cmd(4, 2, 1, 0, "set_end_on_start");
    chk("end_literal", {51'b0, EndPoint}, 64'd0);

    {ram[43], ram[42], ram[41], ram[40]} = 32'h0300_0403;
    {mgrid[43], mgrid[42], mgrid[41], mgrid[40]} = 32'h0300_0403;
    do_cmd(5, 0, 0, 0, "sweep_word10");
    if (wlog.size() == 1)
      chk("sweep_word10_wr", {30'b0, wlog[0]}, {30'b0, 10'd10, 4'b1001, 32'h0});

    // Commands offered while locked are refused
    @(posedge Clk); #1;
    wlog.delete(); lock = 1; cmd_valid = 1; cmd_op = 3'd1; cmd_x = 6'd9; cmd_y = 6'd9;
    repeat (6) begin
      @(posedge Clk); #1;
      chk("locked_ready", {62'b0, cmd_ready, busy}, 64'd0);
    end
    cmd_valid = 0; lock = 0;
    chk("locked_writes", 64'(wlog.size()), 64'd0);

    rand_wait = 1;
    for (int n = 0; n < 70; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin op = 5; sprinkle_path(40); end
      else if (r < 6) op = 6;
      else op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 1) == 1) begin x = $urandom_range(1, 4); y = $urandom_range(1, 2); end
      else begin x = $urandom_range(0, 63); y = $urandom_range(0, 63); end
      do_cmd(op, x, y, $urandom_range(0, 3) == 0, "rand");
    end

    // Reset in the middle of a path sweep
    sprinkle_path(40);
    @(posedge Clk); #1;
    cmd_valid = 1; cmd_op = 3'd5; cmd_x = 0; cmd_y = 0;
    @(posedge Clk); #1;
    cmd_valid = 0;
    t = 0;
    repeat (200) begin @(posedge Clk); t++; end
    #1;
    chk("mid_sweep_busy", {63'b0, busy}, 64'd1);
    Reset = 1;
    #1 check_reset_outputs("mid_reset");
    for (int p = 0; p < 2; p++) begin px[p] = 0; py[p] = 0; pv[p] = 0; end
    repeat (2) @(posedge Clk);
    for (int i = 0; i < NCELL; i++) mgrid[i] = ram[i];
    #1 Reset = 0;
    do_cmd(5, 0, 0, 0, "sweep_after_reset");
    do_cmd(3, 3, 3, 0, "final_start");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
